sbox_share_sched: RTL and testbench



---
 rtl/sbox_share_sched_pkg.sv | 28 ++
 rtl/sbox_share_sched_tag_pipe.sv | 31 +++
 rtl/sbox_share_sched.sv | 144 ++++++++++++++
 tb/tb_sbox_share_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_share_sched_pkg.sv
// Shared types and constants for the S-box bank scheduler.
package sbox_share_sched_pkg;

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STATE_W  = 128;

    // Identifies what the word travelling through the bank belongs to.
    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_KEY,
        TAG_COL0,
        TAG_COL1,
        TAG_COL2,
        TAG_COL3
    } tag_t;

    // Tag for state column index 0..3.
    function automatic tag_t col_tag(input logic [1:0] col);
        case (col)
            2'd0:    return TAG_COL0;
            2'd1:    return TAG_COL1;
            2'd2:    return TAG_COL2;
            default: return TAG_COL3;
        endcase
    endfunction

endpackage

// File: rtl/sbox_share_sched_tag_pipe.sv
// Tag shift register that tracks words through the registered S-box bank.
module sbox_tag_pipe
    import sbox_share_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [DEPTH];

    // Shift tags one stage per clock; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                stage[k] <= TAG_NONE;
            end
        end else begin
            stage[0] <= tag_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/sbox_share_sched.sv
// Shares one 4-lane S-box bank between the round SubBytes (4 column beats)
// and the key-expansion SubWord (1 beat).
module sbox_share_sched
    import sbox_share_sched_pkg::*;
#(
    parameter int unsigned SBOX_LAT     = 1,
    parameter int unsigned KEY_PRIORITY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               st_req_valid,
    output logic               st_req_ready,
    input  logic [STATE_W-1:0] st_req_data,
    output logic               st_rsp_valid,
    input  logic               st_rsp_ready,
    output logic [STATE_W-1:0] st_rsp_data,
    input  logic               kw_req_valid,
    output logic               kw_req_ready,
    input  logic [WORD_W-1:0]  kw_req_data,
    output logic               kw_rsp_valid,
    input  logic               kw_rsp_ready,
    output logic [WORD_W-1:0]  kw_rsp_data,
    output logic [WORD_W-1:0]  sb_in,
    input  logic [WORD_W-1:0]  sb_out
);

    logic               st_busy;
    logic               kw_busy;
    logic               key_pending;
    logic [2:0]         col_cnt;
    logic [STATE_W-1:0] st_buf;
    logic [WORD_W-1:0]  kw_buf;

    logic cols_left;
    logic issue_key;
    logic issue_col;
    logic st_acc;
    logic kw_acc;
    logic st_done;
    logic kw_done;
    tag_t issue_tag;
    tag_t tag_out;

    assign st_req_ready = ~st_busy;
    assign kw_req_ready = ~kw_busy;
    assign st_acc  = st_req_valid & ~st_busy;
    assign kw_acc  = kw_req_valid & ~kw_busy;
    assign st_done = st_rsp_valid & st_rsp_ready;
    assign kw_done = kw_rsp_valid & kw_rsp_ready;

    // Pick the word for this cycle's issue slot and its tag.
    always_comb begin
        cols_left = st_busy && (col_cnt < 3'(NUM_COLS));
        issue_key = key_pending && ((KEY_PRIORITY != 0) || !cols_left);
        issue_col = cols_left && !issue_key;
        sb_in     = '0;
        issue_tag = TAG_NONE;
        if (issue_key) begin
            sb_in     = kw_buf;
            issue_tag = TAG_KEY;
        end else if (issue_col) begin
            for (int unsigned k = 0; k < NUM_COLS; k++) begin
                if (col_cnt[1:0] == k[1:0]) begin
                    sb_in = st_buf[k*WORD_W +: WORD_W];
                end
            end
            issue_tag = col_tag(col_cnt[1:0]);
        end
    end

    // Job acceptance, busy tracking and issue progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_busy     <= 1'b0;
            kw_busy     <= 1'b0;
            key_pending <= 1'b0;
            col_cnt     <= '0;
            st_buf      <= '0;
            kw_buf      <= '0;
        end else begin
            if (st_acc) begin
                st_busy <= 1'b1;
                st_buf  <= st_req_data;
                col_cnt <= '0;
            end else if (st_done) begin
                st_busy <= 1'b0;
            end
            if (issue_col) begin
                col_cnt <= col_cnt + 3'd1;
            end
            if (kw_acc) begin
                kw_busy     <= 1'b1;
                key_pending <= 1'b1;
                kw_buf      <= kw_req_data;
            end else if (kw_done) begin
                kw_busy <= 1'b0;
            end
            if (issue_key) begin
                key_pending <= 1'b0;
            end
        end
    end

    sbox_tag_pipe #(
        .DEPTH(SBOX_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (issue_tag),
        .tag_out(tag_out)
    );

    // Route bank output into the response register named by the exiting tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_rsp_valid <= 1'b0;
            st_rsp_data  <= '0;
            kw_rsp_valid <= 1'b0;
            kw_rsp_data  <= '0;
        end else begin
            if (st_done) begin
                st_rsp_valid <= 1'b0;
            end
            if (kw_done) begin
                kw_rsp_valid <= 1'b0;
            end
            case (tag_out)
                TAG_KEY: begin
                    kw_rsp_data  <= sb_out;
                    kw_rsp_valid <= 1'b1;
                end
                TAG_COL0: st_rsp_data[31:0]  <= sb_out;
                TAG_COL1: st_rsp_data[63:32] <= sb_out;
                TAG_COL2: st_rsp_data[95:64] <= sb_out;
                TAG_COL3: begin
                    st_rsp_data[127:96] <= sb_out;
                    st_rsp_valid        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_share_sched.sv
// Self-checking bench: instance 1 uses key priority, instance 0 state priority.
module tb_sbox_share_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         st_req_valid [2];
    logic         st_req_ready [2];
    logic [127:0] st_req_data  [2];
    logic         st_rsp_valid [2];
    logic         st_rsp_ready [2];
    logic [127:0] st_rsp_data  [2];
    logic         kw_req_valid [2];
    logic         kw_req_ready [2];
    logic [31:0]  kw_req_data  [2];
    logic         kw_rsp_valid [2];
    logic         kw_rsp_ready [2];
    logic [31:0]  kw_rsp_data  [2];
    logic [31:0]  sb_in        [2];
    logic [31:0]  sb_out       [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_tab[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = sub_word(s[32*i +: 32]);
        return r;
    endfunction

    // Bank model: registered byte substitution, one cycle of latency.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) sb_out[d] <= sub_word(sb_in[d]);
    end

    sbox_share_sched #(.SBOX_LAT(1), .KEY_PRIORITY(0)) dut0 (
        .clk(clk), .rst(rst),
        .st_req_valid(st_req_valid[0]), .st_req_ready(st_req_ready[0]), .st_req_data(st_req_data[0]),
        .st_rsp_valid(st_rsp_valid[0]), .st_rsp_ready(st_rsp_ready[0]), .st_rsp_data(st_rsp_data[0]),
        .kw_req_valid(kw_req_valid[0]), .kw_req_ready(kw_req_ready[0]), .kw_req_data(kw_req_data[0]),
        .kw_rsp_valid(kw_rsp_valid[0]), .kw_rsp_ready(kw_rsp_ready[0]), .kw_rsp_data(kw_rsp_data[0]),
        .sb_in(sb_in[0]), .sb_out(sb_out[0])
    );

    sbox_share_sched #(.SBOX_LAT(1), .KEY_PRIORITY(1)) dut1 (
        .clk(clk), .rst(rst),
        .st_req_valid(st_req_valid[1]), .st_req_ready(st_req_ready[1]), .st_req_data(st_req_data[1]),
        .st_rsp_valid(st_rsp_valid[1]), .st_rsp_ready(st_rsp_ready[1]), .st_rsp_data(st_rsp_data[1]),
        .kw_req_valid(kw_req_valid[1]), .kw_req_ready(kw_req_ready[1]), .kw_req_data(kw_req_data[1]),
        .kw_rsp_valid(kw_rsp_valid[1]), .kw_rsp_ready(kw_rsp_ready[1]), .kw_rsp_data(kw_rsp_data[1]),
        .sb_in(sb_in[1]), .sb_out(sb_out[1])
    );

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk({tag, "_st_rsp_valid"}, 160'(st_rsp_valid[d]), 160'(0));
        chk({tag, "_kw_rsp_valid"}, 160'(kw_rsp_valid[d]), 160'(0));
        chk({tag, "_st_req_ready"}, 160'(st_req_ready[d]), 160'(1));
        chk({tag, "_kw_req_ready"}, 160'(kw_req_ready[d]), 160'(1));
        chk({tag, "_sb_in"}, 160'(sb_in[d]), 160'(0));
    endtask

    // One isolated job; lat = edges from acceptance to first cycle with valid high.
    task automatic run_job(input int d, input bit is_key, input logic [127:0] data,
                           output logic [127:0] got, output int lat);
        @(negedge clk);
        if (is_key) begin
            kw_req_valid[d] = 1'b1;
            kw_req_data[d]  = data[31:0];
        end else begin
            st_req_valid[d] = 1'b1;
            st_req_data[d]  = data;
        end
        @(negedge clk);
        kw_req_valid[d] = 1'b0;
        st_req_valid[d] = 1'b0;
        lat = 0;
        while (!(is_key ? kw_rsp_valid[d] : st_rsp_valid[d]) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        got = is_key ? {96'b0, kw_rsp_data[d]} : st_rsp_data[d];
        if (is_key) kw_rsp_ready[d] = 1'b1;
        else        st_rsp_ready[d] = 1'b1;
        @(negedge clk);
        kw_rsp_ready[d] = 1'b0;
        st_rsp_ready[d] = 1'b0;
    endtask

    // State accepted at edge 0, key accepted at edge kd; latencies counted from edge 0.
    task automatic conc(input int d, input int kd, input logic [127:0] sd, input logic [31:0] kwd,
                        input int exp_st, input int exp_kw, input string tag);
        int st_lat = -1;
        int kw_lat = -1;
        @(negedge clk);
        st_req_valid[d] = 1'b1;
        st_req_data[d]  = sd;
        kw_req_data[d]  = kwd;
        if (kd == 0) kw_req_valid[d] = 1'b1;
        for (int c = 0; c < 40 && (st_lat < 0 || kw_lat < 0); c++) begin
            @(negedge clk);
            if (c == 0) st_req_valid[d] = 1'b0;
            if (kd > 0 && c == kd - 1) kw_req_valid[d] = 1'b1;
            if (c == kd) kw_req_valid[d] = 1'b0;
            if (st_lat < 0 && st_rsp_valid[d]) st_lat = c;
            if (kw_lat < 0 && kw_rsp_valid[d]) kw_lat = c;
        end
        chk({tag, "_st_lat"}, 160'(st_lat), 160'(exp_st));
        chk({tag, "_kw_lat"}, 160'(kw_lat), 160'(exp_kw));
        chk({tag, "_st_data"}, 160'(st_rsp_data[d]), 160'(sub_bytes(sd)));
        chk({tag, "_kw_data"}, 160'(kw_rsp_data[d]), 160'(sub_word(kwd)));
        st_rsp_ready[d] = 1'b1;
        kw_rsp_ready[d] = 1'b1;
        @(negedge clk);
        st_rsp_ready[d] = 1'b0;
        kw_rsp_ready[d] = 1'b0;
        check_idle(d, {tag, "_after"});
    endtask

    typedef struct {
        bit           is_key;
        logic [127:0] din;
        logic [127:0] dout;
        int           lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] got;
        logic [127:0] hold_a;
        logic [127:0] data_b;
        int lat;

        vecs[0] = '{1'b0, 128'h00102030405060708090a0b0c0d0e0f0, 128'h63cab7040953d051cd60e0e7ba70e18c, 5};
        vecs[1] = '{1'b1, 128'hcf4f3c09, 128'h8a84eb01, 2};
        vecs[2] = '{1'b0, {16{8'hff}}, {16{8'h16}}, 5};
        vecs[3] = '{1'b1, 128'h0, 128'h63636363, 2};
        vecs[4] = '{1'b0, 128'h0, {16{8'h63}}, 5};
        vecs[5] = '{1'b1, 128'hffffffff, 128'h16161616, 2};

        for (int d = 0; d < 2; d++) begin
            st_req_valid[d] = 1'b0; st_req_data[d] = '0; st_rsp_ready[d] = 1'b0;
            kw_req_valid[d] = 1'b0; kw_req_data[d] = '0; kw_rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle(d, "reset");
            chk("reset_st_data", 160'(st_rsp_data[d]), 160'(0));
            chk("reset_kw_data", 160'(kw_rsp_data[d]), 160'(0));
        end
        rst = 1'b0;

        // Uncontended table on both priority settings.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 6; i++) begin
                run_job(d, vecs[i].is_key, vecs[i].din, got, lat);
                chk($sformatf("vec%0d_dut%0d_data", i, d), 160'(got), 160'(vecs[i].dout));
                chk($sformatf("vec%0d_dut%0d_lat", i, d), 160'(lat), 160'(vecs[i].lat));
            end
        end

        // Contention: key pre-empts (dut1) or waits behind all columns (dut0).
        conc(1, 1, 128'h00102030405060708090a0b0c0d0e0f0, 32'h00000000, 6, 3, "kp1_mid");
        conc(1, 0, 128'h0123456789abcdeffedcba9876543210, 32'hcf4f3c09, 6, 2, "kp1_same");
        conc(0, 0, 128'h00102030405060708090a0b0c0d0e0f0, 32'hcf4f3c09, 5, 6, "kp0_same");
        conc(0, 1, 128'hdeadbeef0badf00d1234567890abcdef, 32'h00000000, 5, 6, "kp0_mid");

        // Backpressure: response held, next request blocked until one cycle after handshake.
        hold_a = 128'h3243f6a8885a308d313198a2e0370734;
        data_b = 128'h00112233445566778899aabbccddeeff;
        @(negedge clk);
        st_req_valid[1] = 1'b1;
        st_req_data[1]  = hold_a;
        @(negedge clk);
        st_req_valid[1] = 1'b0;
        lat = 0;
        while (!st_rsp_valid[1] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_first_lat", 160'(lat), 160'(5));
        st_req_valid[1] = 1'b1;
        st_req_data[1]  = data_b;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_hold", {31'b0, st_rsp_valid[1], st_rsp_data[1]}, {31'b0, 1'b1, sub_bytes(hold_a)});
            chk("bp_req_ready", 160'(st_req_ready[1]), 160'(0));
        end
        st_rsp_ready[1] = 1'b1;
        @(negedge clk);
        st_rsp_ready[1] = 1'b0;
        chk("bp_ready_after_hs", 160'(st_req_ready[1]), 160'(1));
        chk("bp_valid_after_hs", 160'(st_rsp_valid[1]), 160'(0));
        @(negedge clk);
        chk("bp_next_accepted", 160'(st_req_ready[1]), 160'(0));
        st_req_valid[1] = 1'b0;
        lat = 0;
        while (!st_rsp_valid[1] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_second_lat", 160'(lat), 160'(5));
        chk("bp_second_data", 160'(st_rsp_data[1]), 160'(sub_bytes(data_b)));
        st_rsp_ready[1] = 1'b1;
        @(negedge clk);
        st_rsp_ready[1] = 1'b0;

        // Reset with columns in flight, then a clean job.
        @(negedge clk);
        st_req_valid[1] = 1'b1;
        st_req_data[1]  = 128'hcafebabe_11223344_55667788_99aabbcc;
        kw_req_valid[1] = 1'b1;
        kw_req_data[1]  = 32'h01020304;
        @(negedge clk);
        st_req_valid[1] = 1'b0;
        kw_req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle(1, "rst_mid");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_stray_st", 160'(st_rsp_valid[1]), 160'(0));
            chk("rst_no_stray_kw", 160'(kw_rsp_valid[1]), 160'(0));
        end
        run_job(1, 1'b0, {16{8'hff}}, got, lat);
        chk("rst_after_data", 160'(got), 160'({16{8'h16}}));
        chk("rst_after_lat", 160'(lat), 160'(5));

        // Randomized traffic against a bytewise substitution scoreboard.
        for (int d = 0; d < 2; d++) begin
            logic [127:0] st_q [$];
            logic [31:0]  kw_q [$];
            logic         ps_v = 1'b0, ps_r = 1'b0, pk_v = 1'b0, pk_r = 1'b0;
            logic [127:0] ps_d = '0;
            logic [31:0]  pk_d = '0;
            logic         rs, rk, vs, vk;
            logic [127:0] nd;
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                rs = (cyc >= 340) ? 1'b1 : (($urandom % 4) != 0);
                rk = (cyc >= 340) ? 1'b1 : (($urandom % 3) != 0);
                st_rsp_ready[d] = rs;
                kw_rsp_ready[d] = rk;
                if (ps_v && !ps_r)
                    chk("rnd_st_hold", {31'b0, st_rsp_valid[d], st_rsp_data[d]}, {31'b0, 1'b1, ps_d});
                if (pk_v && !pk_r)
                    chk("rnd_kw_hold", 160'({kw_rsp_valid[d], kw_rsp_data[d]}), 160'({1'b1, pk_d}));
                if (st_rsp_valid[d] && rs) begin
                    chk("rnd_st_expected", 160'(st_q.size() > 0), 160'(1));
                    if (st_q.size() > 0) chk("rnd_st_data", 160'(st_rsp_data[d]), 160'(st_q.pop_front()));
                end
                if (kw_rsp_valid[d] && rk) begin
                    chk("rnd_kw_expected", 160'(kw_q.size() > 0), 160'(1));
                    if (kw_q.size() > 0) chk("rnd_kw_data", 160'(kw_rsp_data[d]), 160'(kw_q.pop_front()));
                end
                ps_v = st_rsp_valid[d]; ps_r = rs; ps_d = st_rsp_data[d];
                pk_v = kw_rsp_valid[d]; pk_r = rk; pk_d = kw_rsp_data[d];
                vs = (cyc < 320) && (($urandom % 3) == 0);
                vk = (cyc < 320) && (($urandom % 4) == 0);
                nd = {$urandom, $urandom, $urandom, $urandom};
                st_req_valid[d] = vs;
                st_req_data[d]  = nd;
                kw_req_valid[d] = vk;
                kw_req_data[d]  = nd[31:0] ^ 32'h5a5a5a5a;
                if (vs && st_req_ready[d]) st_q.push_back(sub_bytes(nd));
                if (vk && kw_req_ready[d]) kw_q.push_back(sub_word(nd[31:0] ^ 32'h5a5a5a5a));
            end
            st_rsp_ready[d] = 1'b0;
            kw_rsp_ready[d] = 1'b0;
            chk("rnd_st_drained", 160'(st_q.size()), 160'(0));
            chk("rnd_kw_drained", 160'(kw_q.size()), 160'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
